obstacle_scheduler: RTL and testbench
=====================================

# obstacle_scheduler

Spawn scheduler for the runner game's obstacle datapath. While the game screen is active it paces obstacle launches on the frame tick, allocates a free obstacle slot (lowest index first), and draws a pseudo-random lane. It ramps difficulty over time by shortening the spawn gap and raising the speed level, and it keeps the run score. It sits between the top-level screen FSM (which supplies `game_en`) and the obstacle sprite/collision datapath (which owns the slots).

## Interface
- `SLOTS`, 4 — number of obstacle slots in the datapath (2..4)
- `INIT_GAP`, 90 — frame ticks between spawns at level 0
- `MIN_GAP`, 30 — floor for the spawn gap
- `GAP_STEP`, 10 — gap reduction per level-up
- `LEVEL_TICKS`, 600 — frame ticks per level
- `LFSR_SEED`, 16'hACE1 — lane LFSR reset value; must be non-zero

- `clk` input 1 — system clock
- `rst` input 1 — reset, asynchronous, active-high
- `frame_tick` input 1 — one-cycle pulse per video frame
- `game_en` input 1 — high while the screen FSM is in the game state
- `slot_free` input SLOTS — bit i high = slot i idle and available
- `spawn_ack` input 1 — datapath accepted the current spawn
- `spawn_valid` output 1 — spawn request pending
- `spawn_slot` output 2 — slot to load; stable while `spawn_valid`
- `spawn_lane` output 2 — lane 0..2; stable while `spawn_valid`
- `level` output 4 — difficulty/speed level, 0..15
- `score` output 16 — frame ticks survived in the current run

## Operation
- Reset values:
  - state IDLE, `spawn_valid` 0, `spawn_slot` 0, `spawn_lane` 0, `level` 0, `score` 0
  - `cur_gap` = INIT_GAP, `gap_cnt` 0, `level_cnt` 0, LFSR = LFSR_SEED
- States and transitions:
  - **IDLE**:
    - Entered whenever `game_en` = 0, from any state, on the next clock.
    - Outputs hold except `spawn_valid` = 0.
    - `score` and `level` hold for death-screen display.
  - **Game start** (IDLE with `game_en` = 1):
    - Clear `score`, `level`, `level_cnt`.
    - Set `cur_gap` = INIT_GAP and `gap_cnt` = INIT_GAP.
    - Go to WAIT.
  - **WAIT**:
    - On each `frame_tick`, decrement `gap_cnt`.
    - A `frame_tick` with `gap_cnt` = 1 goes to PICK.
  - **PICK** (one cycle):
    - If any `slot_free` bit is set, latch the lowest set index into `spawn_slot`, latch the lane, and go to ISSUE.
    - If no slot is free, set `gap_cnt` = 1 and return to WAIT. This retries on the next `frame_tick`.
  - **ISSUE**:
    - `spawn_valid` = 1, decoded from state.
    - On `spawn_ack`, set `gap_cnt` = `cur_gap` and go to WAIT.
- Lane: LFSR bits [1:0]; value 3 maps to lane 0.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every clock while `game_en` = 1, so lane choice depends on player timing.
- Difficulty:
  - In any non-IDLE state, each `frame_tick` increments `level_cnt`.
  - When `level_cnt` reaches LEVEL_TICKS-1 on a tick:
    - `level_cnt` clears.
    - `level` increments, saturating at 15.
    - `cur_gap` = max(MIN_GAP, `cur_gap` − GAP_STEP).
  - At level 15, `cur_gap` still steps toward MIN_GAP.
- Score: each `frame_tick` in any non-IDLE state increments `score`, saturating at 16'hFFFF.
- `frame_tick` during PICK or ISSUE does not decrement `gap_cnt`. It still counts for `score` and `level_cnt`.
- A `cur_gap` update during ISSUE takes effect at the reload on `spawn_ack`.

## Timing
- Tick processing and spawn latency:
  - `frame_tick` sampled at edge T with `gap_cnt` = 1 → state PICK at T+1.
  - `spawn_valid` = 1 from T+2.
- Handshake:
  - `spawn_slot` and `spawn_lane` are valid and stable for the whole time `spawn_valid` is high.
  - Transfer happens on a clock with `spawn_valid` & `spawn_ack`.
  - `spawn_valid` falls on the next cycle.
  - `spawn_ack` with `spawn_valid` = 0 is ignored.
- `game_en` falling:
  - Any pending request is aborted; `spawn_valid` = 0 one clock later.
  - No slot is consumed.
- `rst` asynchronously forces all reset values regardless of the clock.
- Simultaneous `game_en` rise and `frame_tick`: the tick is not counted. Counting starts in WAIT.

## Structure
- Shared package `game_pkg`:
  - state encodings (IDLE, WAIT, PICK, ISSUE)
  - lane count 3
  - LFSR tap constant 16'hB400
  - screen state defines `scr_start` 1, `scr_game` 2, `scr_death` 3; the top level derives `game_en` = (state == `scr_game`)
- Sub-module `lfsr16`:
  - ports `clk`, `rst`, `en`, `q[15:0]`
  - seed parameter
- Slot priority encoder, difficulty counters and FSM stay inline.

## Test plan
- Reset, then `game_en` = 1, all slots free, `frame_tick` every 10 cycles, `spawn_ack` 1 cycle after valid → first `spawn_valid` 2 cycles after the 90th tick, `spawn_slot` 0, `spawn_lane` = LFSR-derived reference value.
- `slot_free` = 4'b0000 at PICK, then 4'b0100 → no valid; retry on next tick; `spawn_slot` = 2.
- Hold `spawn_ack` low for 50 cycles with ticks arriving → `spawn_valid`, `spawn_slot`, `spawn_lane` stable; `gap_cnt` reloads only after ack.
- Run 600 ticks → `level` = 1, next gap 80. After 6 levels gap = 30. At 15 levels `level` stays 15.
- Drop `game_en` during ISSUE → `spawn_valid` 0 next cycle. `score` holds its value. Re-raise `game_en` → `score` 0, `level` 0.
- Assert `rst` mid-ISSUE between clock edges → `spawn_valid` 0 immediately, LFSR = 16'hACE1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the runner game: scheduler states, lane count,
// LFSR taps and the screen-FSM encodings used to derive game_en.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PICK  = 2'd2,
    ST_ISSUE = 2'd3
  } sched_state_t;

  localparam int          LANES     = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          CNT_W     = 16;

  // Screen FSM encodings; the top level drives game_en = (scr_state == SCR_GAME)
  localparam logic [1:0] SCR_START = 2'd1;
  localparam logic [1:0] SCR_GAME  = 2'd2;
  localparam logic [1:0] SCR_DEATH = 2'd3;

  // Two random bits give 0..3; the out-of-range value folds onto lane 0
  function automatic logic [1:0] lane_of(input logic [1:0] bits);
    return (bits == 2'(LANES)) ? 2'd0 : bits;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Galois LFSR used as the lane random source.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // Shift right, folding the taps in whenever a one falls out of bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: paces launches on the frame tick, picks the
// lowest free slot and a random lane, ramps difficulty and keeps the score.
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int          SLOTS       = 4,
  parameter int          INIT_GAP    = 90,
  parameter int          MIN_GAP     = 30,
  parameter int          GAP_STEP    = 10,
  parameter int          LEVEL_TICKS = 600,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             game_en,
  input  logic [SLOTS-1:0] slot_free,
  input  logic             spawn_ack,
  output logic             spawn_valid,
  output logic [1:0]       spawn_slot,
  output logic [1:0]       spawn_lane,
  output logic [3:0]       level,
  output logic [15:0]      score
);

  localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_INIT_GAP   = CNT_W'(INIT_GAP);
  localparam logic [CNT_W-1:0] L_MIN_GAP    = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] L_GAP_STEP   = CNT_W'(GAP_STEP);
  localparam logic [CNT_W-1:0] L_GAP_FLOOR  = CNT_W'(MIN_GAP + GAP_STEP);
  localparam logic [CNT_W-1:0] L_LEVEL_LAST = CNT_W'(LEVEL_TICKS - 1);

  sched_state_t     r_state, w_state_nxt;
  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr;
  logic [1:0]       r_slot, r_lane, w_free_idx;
  logic             w_any_free;
  logic [3:0]       r_level;
  logic [15:0]      r_score;
  logic [CNT_W-1:0] r_cur_gap, r_gap_cnt, r_level_cnt, w_cur_gap_nxt;
  logic             w_tick_run, w_level_up;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (game_en),
    .q   (w_lfsr)
  );

  // Upper LFSR bits only feed the sequence itself, never the lane
  assign w_unused_lfsr = ^w_lfsr[15:2];

  // Lowest-index free slot wins: scan downward so the last hit is the lowest
  always_comb begin
    w_free_idx = 2'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_free[i]) w_free_idx = 2'(i);
    end
  end

  assign w_any_free = |slot_free;
  assign w_tick_run = frame_tick && (r_state != ST_IDLE);
  assign w_level_up = w_tick_run && (r_level_cnt == L_LEVEL_LAST);

  // Spawn gap after this cycle's possible level-up, clamped at the floor;
  // also used for the reload on ack so a same-cycle level-up is not lost
  always_comb begin
    w_cur_gap_nxt = r_cur_gap;
    if (w_level_up) begin
      w_cur_gap_nxt = (r_cur_gap >= L_GAP_FLOOR) ? (r_cur_gap - L_GAP_STEP) : L_MIN_GAP;
    end
  end

  // Scheduler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; leaving the game screen aborts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (!game_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_WAIT;
        ST_WAIT:  if (frame_tick && (r_gap_cnt == L_ONE)) w_state_nxt = ST_PICK;
        ST_PICK:  w_state_nxt = w_any_free ? ST_ISSUE : ST_WAIT;
        ST_ISSUE: if (spawn_ack) w_state_nxt = ST_WAIT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Run counters, spawn pacing and the latched slot/lane of the pending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot      <= 2'd0;
      r_lane      <= 2'd0;
      r_level     <= 4'd0;
      r_score     <= 16'd0;
      r_cur_gap   <= L_INIT_GAP;
      r_gap_cnt   <= '0;
      r_level_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      // Game start; score and level otherwise hold for the death screen
      if (game_en) begin
        r_score     <= 16'd0;
        r_level     <= 4'd0;
        r_level_cnt <= '0;
        r_cur_gap   <= L_INIT_GAP;
        r_gap_cnt   <= L_INIT_GAP;
      end
    end else begin
      if (w_tick_run) begin
        if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
        if (w_level_up) begin
          r_level_cnt <= '0;
          if (r_level != 4'hF) r_level <= r_level + 4'd1;
        end else begin
          r_level_cnt <= r_level_cnt + L_ONE;
        end
      end
      r_cur_gap <= w_cur_gap_nxt;
      if (game_en) begin
        case (r_state)
          ST_WAIT:  if (frame_tick) r_gap_cnt <= r_gap_cnt - L_ONE;
          ST_PICK: begin
            if (w_any_free) begin
              r_slot <= w_free_idx;
              r_lane <= lane_of(w_lfsr[1:0]);
            end else begin
              r_gap_cnt <= L_ONE;  // retry on the very next tick
            end
          end
          ST_ISSUE: if (spawn_ack) r_gap_cnt <= w_cur_gap_nxt;
          default: ;
        endcase
      end
    end
  end

  assign spawn_valid = (r_state == ST_ISSUE);
  assign spawn_slot  = r_slot;
  assign spawn_lane  = r_lane;
  assign level       = r_level;
  assign score       = r_score;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler: directed sequences, a slot-priority
// vector table and a randomized run, all against a behavioural model.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

  localparam int SLOTS       = 4;
  localparam int INIT_GAP    = 90;
  localparam int MIN_GAP     = 30;
  localparam int GAP_STEP    = 10;
  localparam int LEVEL_TICKS = 600;
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_tick = 1'b0;
  logic             game_en = 1'b0;
  logic             spawn_ack = 1'b0;
  logic [SLOTS-1:0] slot_free = '0;
  logic             spawn_valid;
  logic [1:0]       spawn_slot, spawn_lane;
  logic [3:0]       level;
  logic [15:0]      score;

  int n_cmp = 0;
  int n_bad = 0;

  obstacle_scheduler #(
    .SLOTS(SLOTS), .INIT_GAP(INIT_GAP), .MIN_GAP(MIN_GAP), .GAP_STEP(GAP_STEP),
    .LEVEL_TICKS(LEVEL_TICKS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_en(game_en),
    .slot_free(slot_free), .spawn_ack(spawn_ack), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .spawn_lane(spawn_lane), .level(level), .score(score)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_PICK, M_OFFER} mmode_t;
  mmode_t      m_mode;
  int          m_countdown, m_gap, m_level, m_lvl_ticks, m_score, m_slot, m_lane;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_countdown = 0; m_gap = INIT_GAP; m_level = 0;
    m_lvl_ticks = 0; m_score = 0; m_slot = 0; m_lane = 0; m_lfsr = SEED;
  endtask

  task automatic model_step();
    logic [15:0] nxt_lfsr;
    int first;
    int raw;
    nxt_lfsr = game_en ? lfsr_adv(m_lfsr) : m_lfsr;
    if (m_mode != M_IDLE && frame_tick) begin
      if (m_score < 65535) m_score++;
      m_lvl_ticks++;
      if (m_lvl_ticks == LEVEL_TICKS) begin
        m_lvl_ticks = 0;
        if (m_level < 15) m_level++;
        m_gap = (m_gap - GAP_STEP < MIN_GAP) ? MIN_GAP : m_gap - GAP_STEP;
      end
    end
    if (!game_en) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_score = 0; m_level = 0; m_lvl_ticks = 0;
          m_gap = INIT_GAP; m_countdown = INIT_GAP; m_mode = M_WAIT;
        end
        M_WAIT: if (frame_tick) begin
          m_countdown--;
          if (m_countdown == 0) m_mode = M_PICK;
        end
        M_PICK: begin
          first = -1;
          for (int i = 0; i < SLOTS; i++) if (slot_free[i] && first < 0) first = i;
          if (first >= 0) begin
            m_slot = first;
            raw = int'(m_lfsr) % 4;
            m_lane = (raw == 3) ? 0 : raw;
            m_mode = M_OFFER;
          end else begin
            m_countdown = 1;
            m_mode = M_WAIT;
          end
        end
        M_OFFER: if (spawn_ack) begin
          m_countdown = m_gap;
          m_mode = M_WAIT;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    m_lfsr = nxt_lfsr;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_valid", int'(spawn_valid), (m_mode == M_OFFER) ? 1 : 0);
    chk("model_slot",  int'(spawn_slot),  m_slot);
    chk("model_lane",  int'(spawn_lane),  m_lane);
    chk("model_level", int'(level),       m_level);
    chk("model_score", int'(score),       m_score);
  endtask

  // One clock: advance the model on the same inputs, then compare
  task automatic cyc();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_ack();
    spawn_ack = 1'b1; cyc(); spawn_ack = 1'b0;
  endtask

  // Ticks every third cycle until a request appears; returns ticks used
  task automatic ticks_to_spawn(output int n);
    logic found;
    n = 0; found = 1'b0;
    while (!found && n < 200) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      cyc(); cyc();
      n++;
      found = spawn_valid;
    end
    chk("spawn_seen", int'(found), 1);
  endtask

  typedef struct {
    logic [3:0] free;
    logic [1:0] exp_slot;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, total, sc, spawns;
    logic seen, stable;
    logic [1:0] rs, rl;

    tbl[0] = '{4'b0001, 2'd0};
    tbl[1] = '{4'b0010, 2'd1};
    tbl[2] = '{4'b0110, 2'd1};
    tbl[3] = '{4'b1000, 2'd3};
    tbl[4] = '{4'b1100, 2'd2};
    tbl[5] = '{4'b1111, 2'd0};
    tbl[6] = '{4'b1010, 2'd1};

    model_reset();
    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_slot",  int'(spawn_slot), 0);
    chk("rst_lane",  int'(spawn_lane), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_score", int'(score), 0);

    // First spawn: tick every 10 cycles, all slots free
    game_en = 1'b1; slot_free = 4'hF;
    cyc();
    for (int k = 1; k <= 90; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (k < 90) repeat (9) cyc();
    end
    chk("first_valid_t1", int'(spawn_valid), 0);
    chk("first_score", int'(score), 90);
    cyc();
    chk("first_valid_t2", int'(spawn_valid), 1);
    chk("first_slot", int'(spawn_slot), 0);
    chk("first_lane", int'(spawn_lane), m_lane);
    cyc();
    do_ack();
    chk("first_ack_drop", int'(spawn_valid), 0);

    // No free slot at PICK, then only slot 2 free: retry on the next tick
    slot_free = 4'b0000; seen = 1'b0;
    for (int k = 0; k < 90; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; seen |= spawn_valid;
      cyc(); seen |= spawn_valid;
      cyc(); seen |= spawn_valid;
    end
    chk("nofree_novalid", int'(seen), 0);
    slot_free = 4'b0100;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    cyc(); cyc();
    chk("retry_valid", int'(spawn_valid), 1);
    chk("retry_slot", int'(spawn_slot), 2);

    // Ack held low with ticks arriving: request stays put
    rs = spawn_slot; rl = spawn_lane; stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      frame_tick = (c % 5 == 0); cyc(); frame_tick = 1'b0;
      if (!spawn_valid || spawn_slot != rs || spawn_lane != rl) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    do_ack();
    slot_free = 4'hF;
    ticks_to_spawn(n);
    chk("reload_gap", n, 90);
    do_ack();

    // Difficulty ramp from a fresh game
    game_en = 1'b0; cyc(); cyc();
    game_en = 1'b1; cyc();
    total = 0;
    for (int s = 1; s <= 8; s++) begin
      ticks_to_spawn(n); total += n;
      if (s == 7) begin
        chk("gap_before_lvl1", n, 90);
        chk("level1", int'(level), 1);
      end
      if (s == 8) chk("gap_after_lvl1", n, 80);
      do_ack();
    end
    spawns = 0;
    while (level < 4'd7 && spawns < 300) begin
      ticks_to_spawn(n); total += n; do_ack(); spawns++;
    end
    ticks_to_spawn(n); total += n;
    chk("gap_floor", n, 30);
    do_ack();
    spawns = 0;
    while (total < 15 * LEVEL_TICKS + 700 && spawns < 400) begin
      ticks_to_spawn(n); total += n; do_ack(); spawns++;
    end
    chk("level_sat", int'(level), 15);
    chk("score_total", int'(score), total);

    // Slot priority table
    for (int i = 0; i < 7; i++) begin
      slot_free = tbl[i].free;
      ticks_to_spawn(n);
      chk($sformatf("prio_slot_%0d", i), int'(spawn_slot), int'(tbl[i].exp_slot));
      do_ack();
    end

    // game_en dropped during ISSUE
    slot_free = 4'hF;
    ticks_to_spawn(n);
    sc = score;
    game_en = 1'b0; cyc();
    chk("abort_valid", int'(spawn_valid), 0);
    chk("abort_score", int'(score), sc);
    cyc(); cyc();
    chk("idle_score_hold", int'(score), sc);
    game_en = 1'b1; cyc();
    chk("restart_score", int'(score), 0);
    chk("restart_level", int'(level), 0);

    // Asynchronous reset between edges while a request is pending
    ticks_to_spawn(n);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(spawn_valid), 0);
    chk("arst_lfsr", int'(dut.u_lfsr.q), int'(SEED));
    chk("arst_score", int'(score), 0);
    model_reset();
    rst = 1'b0;
    cyc();
    ticks_to_spawn(n);
    chk("lane_after_rst", int'(spawn_lane), m_lane);
    do_ack();

    // Randomized run
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 299) == 0) game_en = 1'b0;
      else if (!game_en && $urandom_range(0, 3) == 0) game_en = 1'b1;
      frame_tick = ($urandom_range(0, 2) == 0);
      slot_free  = 4'($urandom);
      spawn_ack  = 1'($urandom_range(0, 1));
      cyc();
    end
    frame_tick = 1'b0; spawn_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
